sigmoid_logit: RTL and testbench



---
 rtl/sigmoid_logit_pkg.sv | 74 +++++++
 rtl/sigmoid_logit_if.sv | 22 ++
 rtl/sigmoid_logit_log2_iter.sv | 66 ++++++
 rtl/sigmoid_logit.sv | 143 ++++++++++++++
 tb/tb_sigmoid_logit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sigmoid_logit_pkg.sv
// Shared types, constants and a function-level model for the logit
// (inverse sigmoid) unit.
package sigmoid_logit_pkg;

  localparam int FRAC_BITS = 8;
  localparam int INT_BITS  = 4;
  localparam int LOG_W     = INT_BITS + FRAC_BITS;
  localparam int MAG_W     = 13;

  localparam logic [11:0] SAT_POS = 12'h7FF;
  localparam logic [11:0] SAT_NEG = 12'h801;
  localparam logic [11:0] HALF    = 12'd2048;

  // ln2 ~= 2^-1 + 2^-3 + 2^-4 + 2^-7
  localparam int LN2_SH0 = 1;
  localparam int LN2_SH1 = 3;
  localparam int LN2_SH2 = 4;
  localparam int LN2_SH3 = 7;

  typedef enum logic [2:0] {IDLE, LOG_A, LOG_B, SCALE, OUT} state_e;

  typedef struct packed {
    logic [11:0] f_inv;
    logic        sat;
  } logit_res_t;

  function automatic logic [MAG_W-1:0] ln2_scale(input logic [MAG_W-1:0] d);
    return (d >> LN2_SH0) + (d >> LN2_SH1) + (d >> LN2_SH2) + (d >> LN2_SH3);
  endfunction

  function automatic logic [LOG_W-1:0] log2_model(input logic [11:0] v);
    logic [3:0]           p;
    logic [11:0]          m;
    logic [23:0]          sq;
    logic [FRAC_BITS-1:0] frac;
    p = '0;
    for (int i = 0; i < 12; i++) begin
      if (v[i]) p = 4'(i);
    end
    m    = v << (4'd11 - p);
    frac = '0;
    for (int k = 0; k < FRAC_BITS; k++) begin
      sq   = {12'd0, m} * {12'd0, m};
      frac = {frac[FRAC_BITS-2:0], sq[23]};
      m    = sq[23] ? sq[23:12] : sq[22:11];
    end
    return {p, frac};
  endfunction

  function automatic logit_res_t logit_model(input logic [11:0] y);
    logit_res_t       res;
    logic [11:0]      a;
    logic [11:0]      b;
    logic             neg;
    logic [MAG_W-1:0] d;
    logic [MAG_W-1:0] r;
    logic [11:0]      rc;
    neg = (y < HALF);
    a   = neg ? y : -y;
    b   = -a;
    if (a == '0) begin
      res.f_inv = SAT_NEG;
      res.sat   = 1'b1;
    end else begin
      d         = {1'b0, log2_model(b)} - {1'b0, log2_model(a)};
      r         = ln2_scale(d);
      res.sat   = (r > {1'b0, SAT_POS});
      rc        = res.sat ? SAT_POS : r[11:0];
      res.f_inv = neg ? -rc : rc;
    end
    return res;
  endfunction

endpackage

// File: rtl/sigmoid_logit_if.sv
// Valid/ready request and response bundle for the logit unit.
interface sigmoid_logit_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f_inv;
  logic         sat;

  modport master (
    output in_valid, y, out_ready,
    input  in_ready, out_valid, f_inv, sat
  );

  modport slave (
    input  in_valid, y, out_ready,
    output in_ready, out_valid, f_inv, sat
  );
endinterface

// File: rtl/sigmoid_logit_log2_iter.sv
// Iterative log2 of a 12-bit integer: one normalize cycle, then one
// squaring step per fractional bit, MSB first.
module log2_iter
  import sigmoid_logit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [11:0]      v_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LOG_W-1:0] log_o
);

  localparam int CNT_W = $clog2(FRAC_BITS);

  logic                 busy_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           p_q;
  logic [3:0]           p_lead;
  logic [11:0]          m_q;
  logic [11:0]          m_norm;
  logic [11:0]          m_sq;
  logic [23:0]          sq;
  logic [FRAC_BITS-1:0] frac_q;

  always_comb begin
    // NOTE: default assigned before the scan so no latch is inferred.
    p_lead = '0;
    for (int i = 0; i < 12; i++) begin
      if (v_i[i]) p_lead = 4'(i);
    end
  end

  assign m_norm = v_i << (4'd11 - p_lead);
  assign sq     = {12'd0, m_q} * {12'd0, m_q};
  assign m_sq   = sq[23] ? sq[23:12] : sq[22:11];

  // done_o marks the cycle whose closing edge writes the last fraction bit.
  assign done_o = busy_q && (cnt_q == CNT_W'(FRAC_BITS - 1));
  assign busy_o = busy_q;
  assign log_o  = {p_q, frac_q};

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      p_q    <= '0;
      m_q    <= '0;
      frac_q <= '0;
    end else if (busy_q) begin
      m_q    <= m_sq;
      frac_q <= {frac_q[FRAC_BITS-2:0], sq[23]};
      cnt_q  <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end else if (start_i) begin
      p_q    <= p_lead;
      m_q    <= m_norm;
      frac_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sigmoid_logit.sv
// Logit unit: x = ln(y/(1-y)) for Q0.12 y, producing a saturated Q3.8 result.
module sigmoid_logit #(
  parameter int FRAC_BITS = 8,
  parameter int W         = 12
) (
  input  logic           clk,
  input  logic           rst,
  sigmoid_logit_if.slave bus
);
  import sigmoid_logit_pkg::*;

  localparam int LW = INT_BITS + FRAC_BITS;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             neg_q, neg_d;
  logic [LW-1:0]    log_a_q, log_a_d;
  logic [W-1:0]     f_inv_q, f_inv_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             fold_neg;
  logic [W-1:0]     fold_a;

  logic             log_start;
  logic             log_busy;
  logic             log_done;
  logic [11:0]      log_v;
  logic [LW-1:0]    log_res;

  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] r_scaled;
  logic [W-1:0]     r_clamp;
  logic             sat_scaled;
  logic [W-1:0]     f_scaled;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.f_inv     = f_inv_q;
  assign bus.sat       = sat_q;

  assign accept   = bus.in_valid && bus.in_ready;
  // Fold onto the lower half so a <= b and the magnitude is never negative.
  assign fold_neg = (bus.y < HALF);
  assign fold_a   = fold_neg ? bus.y : -bus.y;

  // One log2 engine, run first on a, then on b.
  assign log_start = ((state_q == LOG_A) || (state_q == LOG_B)) && !log_busy;
  assign log_v     = (state_q == LOG_B) ? b_q : a_q;

  log2_iter u_log2 (
    .clk     (clk),
    .rst     (rst),
    .start_i (log_start),
    .v_i     (log_v),
    .busy_o  (log_busy),
    .done_o  (log_done),
    .log_o   (log_res)
  );

  always_comb begin
    mag        = (log_res >= log_a_q) ? {1'b0, log_res - log_a_q}
                                      : {1'b0, log_a_q - log_res};
    r_scaled   = ln2_scale(mag);
    sat_scaled = (r_scaled > {1'b0, SAT_POS});
    r_clamp    = sat_scaled ? SAT_POS : r_scaled[W-1:0];
    f_scaled   = neg_q ? -r_clamp : r_clamp;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    neg_d       = neg_q;
    log_a_d     = log_a_q;
    f_inv_d     = f_inv_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = fold_a;
          b_d   = -fold_a;
          neg_d = fold_neg;
          if (fold_a == '0) begin
            f_inv_d     = SAT_NEG;
            sat_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = OUT;
          end else begin
            state_d = LOG_A;
          end
        end
      end
      LOG_A: begin
        if (log_done) state_d = LOG_B;
      end
      LOG_B: begin
        // log2(a) is still on the engine output until b's normalize edge.
        if (log_start) log_a_d = log_res;
        if (log_done)  state_d = SCALE;
      end
      SCALE: begin
        f_inv_d     = f_scaled;
        sat_d       = sat_scaled;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      log_a_q     <= '0;
      f_inv_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      log_a_q     <= log_a_d;
      f_inv_q     <= f_inv_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sigmoid_logit.sv
// Self-checking bench for sigmoid_logit: directed table, corner sequences,
// randomized round trips against an arithmetic reference model.
module tb_sigmoid_logit;
  import sigmoid_logit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sigmoid_logit_if #(.W(12)) bus ();

  sigmoid_logit #(.FRAC_BITS(8), .W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [11:0] y;
    logic [11:0] f;
    logic        s;
    int          lat;
  } vec_t;

  vec_t        vecs[6];
  logic [11:0] f1, f2, nf, f_hold;
  logic        s1, s2;
  int          lat, exp1, yv, edge_n, seen, ghost, guard;
  int          seen_edge[2];
  logic [11:0] seen_f[2];
  logit_res_t  pm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference: log2 by repeated squaring on plain integers.
  function automatic int ref_log2(input int v);
    int p    = 0;
    int frac = 0;
    int m;
    while ((v >> (p + 1)) != 0) p++;
    m = v << (11 - p);
    for (int k = 0; k < 8; k++) begin
      m    = (m * m) / 2048;
      frac = frac * 2;
      if (m >= 4096) begin
        frac++;
        m = m / 2;
      end
    end
    return p * 256 + frac;
  endfunction

  // Returns sat*4096 + f_inv.
  function automatic int ref_logit(input int y);
    int a, d, r, s, f;
    if (y == 0) return 4096 + 'h801;
    a = (y < 2048) ? y : 4096 - y;
    d = ref_log2(4096 - a) - ref_log2(a);
    if (d < 0) d = -d;
    r = d / 2 + d / 8 + d / 16 + d / 128;
    s = (r > 2047) ? 1 : 0;
    if (s == 1) r = 2047;
    f = (y < 2048) ? (4096 - r) % 4096 : r;
    return s * 4096 + f;
  endfunction

  // Called at a negedge; returns at a negedge after the output handshake.
  task automatic do_txn(input logic [11:0] y_in, output logic [11:0] f, output logic s,
                        output int lat_o);
    int g = 0;
    while (bus.in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_before_txn", bus.in_ready, 1);
    bus.y        = y_in;
    bus.in_valid = 1'b1;
    @(posedge clk);
    lat_o = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && lat_o < 40) begin
      @(posedge clk);
      lat_o++;
      @(negedge clk);
    end
    f             = bus.f_inv;
    s             = bus.sat;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{12'd2048, 12'h000, 1'b0, 20};
    vecs[1] = '{12'd3072, 12'h118, 1'b0, 20};
    vecs[2] = '{12'd1024, 12'hEE8, 1'b0, 20};
    vecs[3] = '{12'd0,    12'h801, 1'b1, 1};
    vecs[4] = '{12'd1,    12'h801, 1'b1, 20};
    vecs[5] = '{12'd4095, 12'h7FF, 1'b1, 20};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.y         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_f_inv",     bus.f_inv,     0);
    check("rst_sat",       bus.sat,       0);
    rst = 1'b0;
    #1;
    check("in_ready_after_release", bus.in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].y, f1, s1, lat);
      check($sformatf("tbl_f y=%0d", vecs[i].y),   f1,  vecs[i].f);
      check($sformatf("tbl_sat y=%0d", vecs[i].y), s1,  vecs[i].s);
      check($sformatf("tbl_lat y=%0d", vecs[i].y), lat, vecs[i].lat);
    end

    // Backpressure: result held, new input ignored.
    bus.y        = 12'd3072;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("bp_valid_up", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.y        = 12'd5;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_hold", bus.out_valid, 1);
      check("bp_f_hold",     bus.f_inv,     12'h118);
      check("bp_sat_hold",   bus.sat,       0);
      check("bp_in_ready",   bus.in_ready,  0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_valid_clear", bus.out_valid, 0);
    check("bp_in_ready_back", bus.in_ready, 1);
    ghost = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) ghost = 1;
    end
    check("bp_no_ghost_output", ghost, 0);

    // out_ready held high and in_valid held: 1-cycle dwell, 21-cycle cadence.
    bus.out_ready = 1'b1;
    bus.y         = 12'd3072;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    edge_n = 1;
    @(negedge clk);
    bus.y = 12'd1024;
    seen  = 0;
    while (seen < 2 && edge_n < 80) begin
      if (bus.out_valid === 1'b1) begin
        seen_edge[seen] = edge_n;
        seen_f[seen]    = bus.f_inv;
        seen++;
      end
      if (seen < 2) begin
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        if (edge_n == 22) bus.in_valid = 1'b0;
      end
    end
    check("hold_first_edge",  seen_edge[0], 20);
    check("hold_first_f",     seen_f[0],    12'h118);
    check("hold_second_edge", seen_edge[1], 41);
    check("hold_second_f",    seen_f[1],    12'hEE8);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_valid_clear", bus.out_valid, 0);
    check("hold_in_ready",    bus.in_ready,  1);

    // Asynchronous abort during LOG_B.
    bus.y        = 12'd1000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_f_inv",     bus.f_inv,     0);
    check("abort_sat",       bus.sat,       0);
    check("abort_in_ready",  bus.in_ready,  0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready_release", bus.in_ready, 1);
    ghost = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) ghost = 1;
    end
    check("abort_no_output", ghost, 0);
    do_txn(12'd3072, f1, s1, lat);
    check("post_abort_f",   f1,  12'h118);
    check("post_abort_sat", s1,  0);
    check("post_abort_lat", lat, 20);

    // Random round trips against the reference model plus symmetry.
    for (int i = 0; i < 120; i++) begin
      yv = $urandom_range(4095, 1);
      do_txn(12'(yv), f1, s1, lat);
      exp1 = ref_logit(yv);
      check($sformatf("rand_f y=%0d", yv),   f1,  exp1[11:0]);
      check($sformatf("rand_sat y=%0d", yv), s1,  exp1[12]);
      check($sformatf("rand_lat y=%0d", yv), lat, 20);
      if (yv != 2048) begin
        do_txn(12'(4096 - yv), f2, s2, lat);
        exp1 = ref_logit(4096 - yv);
        check($sformatf("rand_f y=%0d", 4096 - yv), f2, exp1[11:0]);
        nf = -f1;
        check($sformatf("sym_f y=%0d", yv),   f2, nf);
        check($sformatf("sym_sat y=%0d", yv), s2, s1);
      end
    end

    // Strided sweep against the package model.
    for (int y = 1; y < 4096; y += 23) begin
      do_txn(12'(y), f1, s1, lat);
      pm = logit_model(12'(y));
      check($sformatf("sweep_f y=%0d", y),   f1, pm.f_inv);
      check($sformatf("sweep_sat y=%0d", y), s1, pm.sat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
